kbd_text_writer: RTL and testbench

- Consumes the ASCII character stream produced by the keyboard wrapper (char_data / char_ready) and renders it into a text-mode video RAM.
- Buffers characters in a small FIFO and maintains a cursor (row, column).
- Interprets printable and control characters, and issues single-cycle writes to the VRAM write port.
- Sits between the keyboard front end and the text display controller.

---
 rtl/kbd_text_writer_if.sv | 30 +++
 rtl/kbd_text_writer.sv | 150 +++++++++++++++
 tb/tb_kbd_text_writer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/kbd_text_writer_if.sv
// Character-in / VRAM-write bundle between the keyboard front end, the text writer
// and the text display controller.
interface kbd_text_writer_if #(
  parameter int COLS = 80,
  parameter int ROWS = 30
);
  localparam int AW = $clog2(COLS * ROWS);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic [7:0]    char_data;
  logic          char_ready;
  logic          vram_we;
  logic [AW-1:0] vram_addr;
  logic [7:0]    vram_wdata;
  logic [CW-1:0] cursor_col;
  logic [RW-1:0] cursor_row;
  logic          busy;
  logic          overflow;

  modport master (
    output char_data, char_ready,
    input  vram_we, vram_addr, vram_wdata, cursor_col, cursor_row, busy, overflow
  );

  modport slave (
    input  char_data, char_ready,
    output vram_we, vram_addr, vram_wdata, cursor_col, cursor_row, busy, overflow
  );
endinterface

// File: rtl/kbd_text_writer.sv
// Buffers keyboard ASCII in a small FIFO and renders it into text-mode VRAM,
// tracking a wrapping cursor and handling CR/LF, backspace and form-feed clear.
module kbd_text_writer #(
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int FIFO_DEPTH = 8
) (
  input logic              clk,
  input logic              reset,
  kbd_text_writer_if.slave bus
);
  localparam int AW = $clog2(COLS * ROWS);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] LAST_COL   = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(COLS * ROWS - 1);
  localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PROC, CLEAR} state_t;

  state_t        state_reg, state_next;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [PW:0]   count_reg, count_next;
  logic [7:0]    char_reg;
  logic [AW-1:0] clr_addr_reg;
  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [7:0]    wdata_reg;
  logic          busy_reg;
  logic          overflow_reg;

  logic          full, pop, push;
  logic [AW-1:0] cur_addr;
  logic [RW-1:0] row_inc;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
  always_comb begin
    full       = (count_reg == FULL_COUNT);
    pop        = (state_reg == IDLE) && (count_reg != '0);
    push       = bus.char_ready && (!full || pop);
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + 1'b1;
    else if (pop && !push)
      count_next = count_reg - 1'b1;
    cur_addr   = AW'(row_reg) * AW'(COLS) + AW'(col_reg);
    row_inc    = (row_reg == LAST_ROW) ? '0 : row_reg + 1'b1;
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pop) state_next = PROC;
      PROC:    state_next = (char_reg == 8'h0C) ? CLEAR : IDLE;
      CLEAR:   if (clr_addr_reg == LAST_ADDR) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= bus.char_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      char_reg     <= '0;
      clr_addr_reg <= '0;
      col_reg      <= '0;
      row_reg      <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      busy_reg  <= (state_next != IDLE) || (count_next != '0);
      we_reg    <= 1'b0;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (bus.char_ready && full && !pop)
        overflow_reg <= 1'b1;
      if (pop) begin
        char_reg   <= fifo_mem[rd_ptr_reg];
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case (state_reg)
        PROC: begin
          if (char_reg >= 8'h20 && char_reg <= 8'h7E) begin
            we_reg    <= 1'b1;
            addr_reg  <= cur_addr;
            wdata_reg <= char_reg;
            if (col_reg != LAST_COL) begin
              col_reg <= col_reg + 1'b1;
            end else begin
              col_reg <= '0;
              row_reg <= row_inc;
            end
          end else if (char_reg == 8'h0D || char_reg == 8'h0A) begin
            col_reg <= '0;
            row_reg <= row_inc;
          end else if (char_reg == 8'h08) begin
            // Both backspace cases land on the linear address just before the cursor.
            if (col_reg != '0 || row_reg != '0) begin
              we_reg    <= 1'b1;
              addr_reg  <= cur_addr - 1'b1;
              wdata_reg <= 8'h20;
              if (col_reg != '0) begin
                col_reg <= col_reg - 1'b1;
              end else begin
                col_reg <= LAST_COL;
                row_reg <= row_reg - 1'b1;
              end
            end
          end else if (char_reg == 8'h0C) begin
            clr_addr_reg <= '0;
          end
        end
        CLEAR: begin
          we_reg       <= 1'b1;
          addr_reg     <= clr_addr_reg;
          wdata_reg    <= 8'h20;
          clr_addr_reg <= clr_addr_reg + 1'b1;
          if (clr_addr_reg == LAST_ADDR) begin
            col_reg <= '0;
            row_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.vram_we    = we_reg;
  assign bus.vram_addr  = addr_reg;
  assign bus.vram_wdata = wdata_reg;
  assign bus.cursor_col = col_reg;
  assign bus.cursor_row = row_reg;
  assign bus.busy       = busy_reg;
  assign bus.overflow   = overflow_reg;
endmodule

// File: tb/tb_kbd_text_writer.sv
// Directed bench for kbd_text_writer on a 4x2 screen with a 4-entry FIFO.
module tb_kbd_text_writer;
  localparam int COLS  = 4;
  localparam int ROWS  = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  kbd_text_writer_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  kbd_text_writer #(.COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] ch;
    logic       we;
    logic [2:0] addr;
    logic [7:0] data;
    logic [1:0] col;
    logic [0:0] row;
  } vec_t;

  wr_t  wq[$];
  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  always @(negedge clk)
    if (bus.vram_we === 1'b1)
      wq.push_back('{bus.vram_addr, bus.vram_wdata});

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] ch, input logic we, input logic [2:0] addr,
                     input logic [7:0] data, input logic [1:0] col, input logic [0:0] row);
    vecs.push_back('{ch, we, addr, data, col, row});
  endtask

  task automatic strobe(input logic [7:0] c);
    @(posedge clk); #1;
    bus.char_data  = c;
    bus.char_ready = 1'b1;
    @(posedge clk); #1;
    bus.char_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("busy_drop", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic check_write(input string name, input logic [2:0] addr, input logic [7:0] data);
    wr_t w;
    check({name, "_present"}, 32'(wq.size() > 0), 32'd1);
    if (wq.size() > 0) begin
      w = wq.pop_front();
      check({name, "_addr"}, 32'(w.addr), 32'(addr));
      check({name, "_data"}, 32'(w.data), 32'(data));
    end
  endtask

  task automatic check_cursor(input string name, input logic [1:0] col, input logic [0:0] row);
    check({name, "_col"}, 32'(bus.cursor_col), 32'(col));
    check({name, "_row"}, 32'(bus.cursor_row), 32'(row));
  endtask

  initial begin
    // Sequential vectors from a fresh cursor at (row 0, col 0).
    add(8'h41, 1, 3'd0, 8'h41, 2'd1, 1'd0);
    add(8'h42, 1, 3'd1, 8'h42, 2'd2, 1'd0);
    add(8'h43, 1, 3'd2, 8'h43, 2'd3, 1'd0);
    add(8'h44, 1, 3'd3, 8'h44, 2'd0, 1'd1);
    add(8'h45, 1, 3'd4, 8'h45, 2'd1, 1'd1);
    add(8'h46, 1, 3'd5, 8'h46, 2'd2, 1'd1);
    add(8'h47, 1, 3'd6, 8'h47, 2'd3, 1'd1);
    add(8'h48, 1, 3'd7, 8'h48, 2'd0, 1'd0);
    add(8'h49, 1, 3'd0, 8'h49, 2'd1, 1'd0);
    add(8'h08, 1, 3'd0, 8'h20, 2'd0, 1'd0);
    add(8'h08, 0, 3'd0, 8'h00, 2'd0, 1'd0);
    add(8'h41, 1, 3'd0, 8'h41, 2'd1, 1'd0);
    add(8'h42, 1, 3'd1, 8'h42, 2'd2, 1'd0);
    add(8'h0D, 0, 3'd0, 8'h00, 2'd0, 1'd1);
    add(8'h08, 1, 3'd3, 8'h20, 2'd3, 1'd0);
    add(8'h0A, 0, 3'd0, 8'h00, 2'd0, 1'd1);
    add(8'h01, 0, 3'd0, 8'h00, 2'd0, 1'd1);
    add(8'h7F, 0, 3'd0, 8'h00, 2'd0, 1'd1);
    add(8'h7E, 1, 3'd4, 8'h7E, 2'd1, 1'd1);
    add(8'h0A, 0, 3'd0, 8'h00, 2'd0, 1'd0);
    add(8'h20, 1, 3'd0, 8'h20, 2'd1, 1'd0);

    bus.char_data  = 8'h00;
    bus.char_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we", 32'(bus.vram_we), 32'd0);
    check("rst_addr", 32'(bus.vram_addr), 32'd0);
    check("rst_wdata", 32'(bus.vram_wdata), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check_cursor("rst", 2'd0, 1'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    wq.delete();

    // Single 'A': write must appear exactly three cycles after the strobe.
    strobe(8'h41);
    check("lat_busy_t1", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    check("lat_we_t2", 32'(bus.vram_we), 32'd0);
    @(posedge clk); #1;
    check("lat_we_t3", 32'(bus.vram_we), 32'd1);
    check("lat_addr", 32'(bus.vram_addr), 32'd0);
    check("lat_data", 32'(bus.vram_wdata), 32'h41);
    check_cursor("lat", 2'd1, 1'd0);
    wait_idle();
    $display("latency: A written, cursor col=%0d row=%0d", bus.cursor_col, bus.cursor_row);

    pulse_reset();
    check_cursor("rst2", 2'd0, 1'd0);
    wq.delete();

    foreach (vecs[i]) begin
      strobe(vecs[i].ch);
      wait_idle();
      check($sformatf("vec%0d_nwrites", i), 32'(wq.size()), 32'(vecs[i].we));
      if (vecs[i].we && wq.size() > 0)
        check_write($sformatf("vec%0d_wr", i), vecs[i].addr, vecs[i].data);
      check_cursor($sformatf("vec%0d", i), vecs[i].col, vecs[i].row);
      $display("vec %0d ch=0x%02h col=%0d row=%0d", i, vecs[i].ch, bus.cursor_col, bus.cursor_row);
      wq.delete();
    end

    // Form feed immediately followed by 'Z': Z waits in the FIFO until the clear ends.
    @(posedge clk); #1;
    bus.char_data  = 8'h0C;
    bus.char_ready = 1'b1;
    @(posedge clk); #1;
    bus.char_data  = 8'h5A;
    @(posedge clk); #1;
    bus.char_ready = 1'b0;
    wait_idle();
    check("clrz_nwrites", 32'(wq.size()), 32'd9);
    for (int a = 0; a < COLS * ROWS; a++)
      check_write($sformatf("clrz_%0d", a), 3'(a), 8'h20);
    check_write("clrz_z", 3'd0, 8'h5A);
    check_cursor("clrz", 2'd1, 1'd0);
    $display("clear+Z: cursor col=%0d row=%0d", bus.cursor_col, bus.cursor_row);
    wq.delete();

    // Six strobes during a clear into a 4-deep FIFO: last two dropped.
    strobe(8'h0C);
    @(posedge clk); #1;
    check("ovf_before", 32'(bus.overflow), 32'd0);
    for (int k = 0; k < 6; k++) begin
      bus.char_data  = 8'h61 + 8'(k);
      bus.char_ready = 1'b1;
      @(posedge clk); #1;
    end
    bus.char_ready = 1'b0;
    check("ovf_set", 32'(bus.overflow), 32'd1);
    wait_idle();
    check("ovf_nwrites", 32'(wq.size()), 32'd12);
    for (int a = 0; a < COLS * ROWS; a++)
      check_write($sformatf("ovfclr_%0d", a), 3'(a), 8'h20);
    for (int k = 0; k < 4; k++)
      check_write($sformatf("ovfch_%0d", k), 3'(k), 8'h61 + 8'(k));
    check_cursor("ovf", 2'd0, 1'd1);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);
    $display("overflow: flag=%0d cursor col=%0d row=%0d", bus.overflow, bus.cursor_col, bus.cursor_row);
    wq.delete();

    // Reset in the middle of a clear with a character still queued.
    strobe(8'h0C);
    strobe(8'h71);
    repeat (2) @(posedge clk);
    #1;
    check("mid_clear_we", 32'(bus.vram_we), 32'd1);
    pulse_reset();
    wq.delete();
    check("midrst_we", 32'(bus.vram_we), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_ovf", 32'(bus.overflow), 32'd0);
    check_cursor("midrst", 2'd0, 1'd0);
    repeat (20) @(negedge clk);
    check("midrst_nowrites", 32'(wq.size()), 32'd0);
    check("midrst_idle", 32'(bus.busy), 32'd0);
    $display("mid-clear reset: writes after reset=%0d", wq.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
